// File: rtl/minbd_pkg.sv
// rtl/minbd_pkg.sv - shared flit fields, port indices and FSM encoding for the MinBD golden controller
package minbd_pkg;

  localparam int VALID_BIT = 10;
  localparam int SRC_MSB   = 9;
  localparam int SRC_LSB   = 6;

  localparam int PORT_N = 3;
  localparam int PORT_S = 2;
  localparam int PORT_E = 1;
  localparam int PORT_W = 0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/minbd_rr_pick4.sv
// rtl/minbd_rr_pick4.sv - four-way round-robin pick, scanning N->S->E->W from the pointer
module minbd_rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o
);

  logic [1:0] idx;
  logic       found;

  // Port order N=3, S=2, E=1, W=0, so "next port" is a 2-bit decrement.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_i - 2'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/minbd_golden_ctrl.sv
// rtl/minbd_golden_ctrl.sv - MinBD golden/silver port selection, epoch rotation and injection grant
// Defining GOLDEN_STATS_EN adds the saturating golden_cnt output.
module minbd_golden_ctrl #(
  parameter int FLIT_W    = 11,
  parameter int EPOCH_LEN = 64,
  parameter int NUM_NODES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] northad,
  input  logic [FLIT_W-1:0] southad,
  input  logic [FLIT_W-1:0] eastad,
  input  logic [FLIT_W-1:0] westad,
  input  logic              hold,
  input  logic              inj_req,
  output logic [3:0]        golden_vec,
  output logic [3:0]        silver_vec,
  output logic              inj_gnt,
  output logic [3:0]        golden_src
`ifdef GOLDEN_STATS_EN
  ,
  output logic [15:0]       golden_cnt
`endif
);
  import minbd_pkg::*;

  localparam logic [9:0] EPOCH_LAST = 10'(EPOCH_LEN - 1);
  localparam logic [3:0] SRC_LAST   = 4'(NUM_NODES - 1);

  logic [FLIT_W-1:0] flit [4];
  logic [3:0]        src  [4];
  logic [3:0]        valid, gold_hit, silver_req;
  logic [3:0]        golden_d, golden_q, silver_d, silver_q;
  logic [1:0]        rr_ptr_d, rr_ptr_q;
  state_e            state_d, state_q;
  logic [9:0]        epoch_cnt_d, epoch_cnt_q;
  logic [3:0]        golden_src_d, golden_src_q;
  logic              inj_gnt_d, inj_gnt_q;
  logic              run_adv;
  logic              unused_dest_bits;

  assign flit[PORT_N] = northad;
  assign flit[PORT_S] = southad;
  assign flit[PORT_E] = eastad;
  assign flit[PORT_W] = westad;

  assign unused_dest_bits = ^{northad[SRC_LSB-1:0], southad[SRC_LSB-1:0],
                              eastad[SRC_LSB-1:0], westad[SRC_LSB-1:0]};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valid[i]    = flit[i][VALID_BIT];
      src[i]      = flit[i][SRC_MSB:SRC_LSB];
      gold_hit[i] = valid[i] && (src[i] == golden_src_q);
    end
  end

  always_comb begin
    golden_d = '0;
    if (gold_hit[PORT_N])      golden_d[PORT_N] = 1'b1;
    else if (gold_hit[PORT_S]) golden_d[PORT_S] = 1'b1;
    else if (gold_hit[PORT_E]) golden_d[PORT_E] = 1'b1;
    else if (gold_hit[PORT_W]) golden_d[PORT_W] = 1'b1;
  end

  // Only the golden winner is excluded; other flits carrying the golden id may still go silver.
  assign silver_req = valid & ~golden_d;

  minbd_rr_pick4 u_rr_pick (
    .req_i (silver_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (silver_d)
  );

  assign rr_ptr_d = (silver_d != 4'b0000) ? onehot_to_idx(silver_d) - 2'd1 : rr_ptr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  if (hold) state_d = ST_HOLD;
      ST_HOLD: if (!hold) state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // A RUN cycle with hold raised already counts as frozen, including at an epoch boundary.
  assign run_adv = (state_q == ST_RUN) && !hold;

  always_comb begin
    epoch_cnt_d  = epoch_cnt_q;
    golden_src_d = golden_src_q;
    if (run_adv) begin
      if (epoch_cnt_q == EPOCH_LAST) begin
        epoch_cnt_d  = '0;
        golden_src_d = (golden_src_q == SRC_LAST) ? 4'd0 : golden_src_q + 4'd1;
      end else begin
        epoch_cnt_d = epoch_cnt_q + 10'd1;
      end
    end
  end

  assign inj_gnt_d = inj_req && run_adv && !(&valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      epoch_cnt_q  <= '0;
      golden_src_q <= '0;
      rr_ptr_q     <= 2'(PORT_N);
      golden_q     <= '0;
      silver_q     <= '0;
      inj_gnt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      epoch_cnt_q  <= epoch_cnt_d;
      golden_src_q <= golden_src_d;
      rr_ptr_q     <= rr_ptr_d;
      golden_q     <= golden_d;
      silver_q     <= silver_d;
      inj_gnt_q    <= inj_gnt_d;
    end
  end

  assign golden_vec = golden_q;
  assign silver_vec = silver_q;
  assign inj_gnt    = inj_gnt_q;
  assign golden_src = golden_src_q;

`ifdef GOLDEN_STATS_EN
  logic [15:0] golden_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      golden_cnt_q <= '0;
    end else if ((golden_q != 4'b0000) && (golden_cnt_q != 16'hFFFF)) begin
      golden_cnt_q <= golden_cnt_q + 16'd1;
    end
  end

  assign golden_cnt = golden_cnt_q;
`endif

endmodule

// File: tb/tb_minbd_golden_ctrl.sv
// tb/tb_minbd_golden_ctrl.sv - scoreboard bench for minbd_golden_ctrl (EPOCH_LEN=4)
module tb_minbd_golden_ctrl;
  import minbd_pkg::*;

  localparam logic [10:0] IDLE = 11'd0;

  logic        clk;
  logic        rst;
  logic [10:0] northad, southad, eastad, westad;
  logic        hold, inj_req;
  logic [3:0]  golden_vec, silver_vec, golden_src;
  logic        inj_gnt;
`ifdef GOLDEN_STATS_EN
  logic [15:0] golden_cnt;
`endif

  minbd_golden_ctrl #(.FLIT_W(11), .EPOCH_LEN(4), .NUM_NODES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .northad    (northad),
    .southad    (southad),
    .eastad     (eastad),
    .westad     (westad),
    .hold       (hold),
    .inj_req    (inj_req),
    .golden_vec (golden_vec),
    .silver_vec (silver_vec),
    .inj_gnt    (inj_gnt),
    .golden_src (golden_src)
`ifdef GOLDEN_STATS_EN
    ,
    .golden_cnt (golden_cnt)
`endif
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] gv;
    logic [3:0] sv;
    logic       gnt;
    logic [3:0] src;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   armed = 0;

  logic [3:0] exp_b [8] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
    end
  endtask

  function automatic logic [10:0] fl(input logic [3:0] s);
    return {1'b1, s, 6'h2a};
  endfunction

  task automatic step(input logic [10:0] n_f, s_f, e_f, w_f,
                      input logic req_v, hold_v, rst_v,
                      input logic [3:0] gv, sv, input logic gnt, input logic [3:0] src,
                      input string nm);
    exp_t x;
    northad = n_f; southad = s_f; eastad = e_f; westad = w_f;
    inj_req = req_v; hold = hold_v; rst = rst_v;
    x.cyc = cyc + 1; x.name = nm; x.gv = gv; x.sv = sv; x.gnt = gnt; x.src = src;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic req_v, hold_v, rst_v, input logic gnt, input logic [3:0] src, input string nm);
    step(IDLE, IDLE, IDLE, IDLE, req_v, hold_v, rst_v, 4'b0, 4'b0, gnt, src, nm);
  endtask

  // Monitor: compares every expectation due this cycle against the registered outputs.
  initial forever begin
    @(negedge clk);
    if (armed) cmp("overlap", "gv&sv", 32'(golden_vec & silver_vec), 32'd0);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      if (x.cyc < cyc) begin
        cmp(x.name, "stale_cycle", 32'(cyc), 32'(x.cyc));
      end else begin
        cmp(x.name, "golden_vec", 32'(golden_vec), 32'(x.gv));
        cmp(x.name, "silver_vec", 32'(silver_vec), 32'(x.sv));
        cmp(x.name, "inj_gnt",    32'(inj_gnt),    32'(x.gnt));
        cmp(x.name, "golden_src", 32'(golden_src), 32'(x.src));
      end
    end
  end

  initial begin
    rst = 1'b1; hold = 1'b0; inj_req = 1'b0;
    northad = IDLE; southad = IDLE; eastad = IDLE; westad = IDLE;
    @(posedge clk);
    #1;

    // Reset and idle
    idle(0, 0, 1, 0, 4'd0, "reset");
    armed = 1;
    idle(0, 0, 0, 0, 4'd0, "idle_init");
    cmp("idle", "state_run", 32'(dut.state_q), 32'(ST_RUN));
    idle(0, 0, 0, 0, 4'd0, "idle_run1");
    idle(0, 0, 0, 0, 4'd0, "idle_run2");

    // Epoch rotation
    idle(0, 0, 1, 0, 4'd0, "ep_reset");
    idle(0, 0, 0, 0, 4'd0, "ep_init");
    for (int k = 0; k < 8; k++) idle(0, 0, 0, 0, exp_b[k], "epoch_run");

    // Hold on the boundary freezes golden_src
    idle(0, 0, 1, 0, 4'd0, "hb_reset");
    idle(0, 0, 0, 0, 4'd0, "hb_init");
    for (int k = 0; k < 7; k++) idle(0, 0, 0, 0, exp_b[k], "hb_run");
    idle(0, 1, 0, 0, 4'd1, "hb_hold_boundary");
    idle(0, 1, 0, 0, 4'd1, "hb_hold1");
    idle(0, 1, 0, 0, 4'd1, "hb_hold2");
    idle(0, 0, 0, 0, 4'd1, "hb_release");
    idle(0, 0, 0, 0, 4'd2, "hb_resume_wrap");

    // Golden priority and silver selection (frozen by hold, golden_src=0)
    idle(0, 0, 1, 0, 4'd0, "gp_reset");
    step(11'b10000100100, 11'b10000111111, IDLE, IDLE, 0, 1, 0, 4'b1000, 4'b0100, 0, 4'd0, "gp_n_over_s");
    step(IDLE, IDLE, fl(0), fl(0), 0, 1, 0, 4'b0010, 4'b0001, 0, 4'd0, "gp_e_over_w");
    step(fl(5), fl(0), IDLE, IDLE, 0, 1, 0, 4'b0100, 4'b1000, 0, 4'd0, "gp_s_gold");
    step(IDLE, IDLE, IDLE, fl(0), 0, 1, 0, 4'b0001, 4'b0000, 0, 4'd0, "gp_w_only");
    step(IDLE, fl(0), fl(0), IDLE, 0, 1, 0, 4'b0100, 4'b0010, 0, 4'd0, "gp_s_over_e");

    // Round-robin rotation among all-valid non-golden inputs
    idle(0, 0, 1, 0, 4'd0, "rr_reset");
    step(fl(5), fl(5), fl(5), fl(5), 0, 1, 0, 4'b0000, 4'b1000, 0, 4'd0, "rr_n");
    step(fl(5), fl(5), fl(5), fl(5), 0, 1, 0, 4'b0000, 4'b0100, 0, 4'd0, "rr_s");
    step(fl(5), fl(5), fl(5), fl(5), 0, 1, 0, 4'b0000, 4'b0010, 0, 4'd0, "rr_e");
    step(fl(5), fl(5), fl(5), fl(5), 0, 1, 0, 4'b0000, 4'b0001, 0, 4'd0, "rr_w");
    step(fl(5), fl(5), fl(5), fl(5), 0, 1, 0, 4'b0000, 4'b1000, 0, 4'd0, "rr_wrap_n");
    step(fl(0), fl(5), fl(5), fl(5), 0, 1, 0, 4'b1000, 4'b0100, 0, 4'd0, "rr_gold_n");
    step(fl(5), fl(5), fl(5), fl(0), 0, 1, 0, 4'b0001, 4'b0010, 0, 4'd0, "rr_gold_w");
    idle(0, 1, 0, 0, 4'd0, "rr_none");
    step(fl(5), IDLE, IDLE, IDLE, 0, 1, 0, 4'b0000, 4'b1000, 0, 4'd0, "rr_ptr_w_wrap");

    // Injection grant
    idle(0, 0, 1, 0, 4'd0, "inj_reset");
    idle(1, 0, 0, 0, 4'd0, "inj_in_init");
    step(fl(5), fl(5), fl(5), fl(5), 1, 0, 0, 4'b0000, 4'b1000, 0, 4'd0, "inj_4valid");
    step(fl(5), fl(5), fl(5), IDLE, 1, 0, 0, 4'b0000, 4'b0100, 1, 4'd0, "inj_3valid");
    idle(1, 0, 0, 1, 4'd0, "inj_back_to_back");
    idle(0, 0, 0, 0, 4'd1, "inj_drop");

    // Reset mid-epoch and mid-grant
    idle(0, 0, 1, 0, 4'd0, "mr_reset");
    idle(0, 0, 0, 0, 4'd0, "mr_init");
    for (int k = 0; k < 6; k++) idle(0, 0, 0, 0, exp_b[k], "mr_run");
    idle(1, 0, 0, 1, 4'd1, "mr_grant");
    cmp("mr", "epoch_mid", 32'(dut.epoch_cnt_q), 32'd3);
    step(fl(1), IDLE, IDLE, IDLE, 1, 0, 1, 4'b0000, 4'b0000, 0, 4'd0, "mr_rst_pulse");
    cmp("mr", "epoch_cleared", 32'(dut.epoch_cnt_q), 32'd0);
    idle(1, 0, 0, 0, 4'd0, "mr_init_no_gnt");
    idle(1, 0, 0, 1, 4'd0, "mr_regrant");

    // Full rotation of golden_src through 15 back to 0
    idle(0, 0, 1, 0, 4'd0, "wr_reset");
    idle(0, 0, 0, 0, 4'd0, "wr_init");
    for (int k = 1; k <= 64; k++) idle(0, 0, 0, 0, 4'((k / 4) % 16), "wrap_rot");

    idle(0, 0, 0, 0, 4'd0, "tail");
    repeat (2) @(negedge clk);
    cmp("end", "queue_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
